cpu_trace_fifo: RTL and testbench
=================================

Name: cpu_trace_fifo

Overview:
- Downstream consumer of the single-cycle LEGv8 core's observation outputs: PC, 11-bit opcode field, ALU result and data-memory read data.
- Samples one record per clock while tracing is enabled and buffers records in a FIFO.
- Drains records to a debug/host sink over a valid/ready interface.
- Detects the branch-to-self halt idiom and stops capture.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
AW, 4, pointer width, equal to log2(DEPTH)
SEQ_W, 16, width of the sequence and drop counters

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous active-high reset
clear  input  1  synchronous flush; priority over push, pop and state transitions
trace_en  input  1  level enable for capture
cpu_pc  input  64  PC of the instruction executing this cycle
cpu_opcode  input  11  instruction bits [31:21]
cpu_alu  input  64  ALU result
cpu_mem  input  64  data memory read data
out_valid  output  1  head record available
out_ready  input  1  sink accepts the head record
out_pc  output  64  head record PC
out_opcode  output  11  head record opcode
out_alu  output  64  head record ALU result
out_mem  output  64  head record memory data
out_seq  output  SEQ_W  head record sequence number
count  output  AW+1  occupancy, 0..DEPTH
full  output  1  count==DEPTH
empty  output  1  count==0
drop_count  output  SEQ_W  records lost to overflow, saturating
halted  output  1  FSM in HALTED

Behaviour:
- Reset (async, asserted): FIFO pointers, count, seq, drop_count and last_pc = 0; FSM = IDLE. Outputs: out_valid=0, empty=1, full=0, halted=0, count=0, drop_count=0. out_* data fields are 0.
- FSM states: IDLE, RUN, HALTED.
  - IDLE -> RUN when trace_en=1. The IDLE->RUN cycle itself captures.
  - RUN -> IDLE when trace_en=0; no capture that cycle.
  - RUN -> HALTED when capturing and cpu_pc == last_pc. That record is captured; nothing after it is captured.
  - HALTED is left only via clear or reset. trace_en is ignored in HALTED.
- Capture attempt: FSM is in RUN, or transitioning IDLE->RUN, and trace_en=1.
- On each capture attempt:
  - Record {cpu_pc, cpu_opcode, cpu_alu, cpu_mem, seq} is formed.
  - seq increments modulo 2^SEQ_W.
  - last_pc <= cpu_pc.
- Halt compare:
  - Uses last_pc from the previous capture.
  - The first capture after IDLE never compares: last_pc_valid is cleared on entry to IDLE and set on capture.
- Push: capture attempt and (not full, or pop in the same cycle).
- Drop: capture attempt while full and no pop that cycle. drop_count increments, saturating at all-ones. seq still increments, so drops show as gaps in out_seq.
- Pop: out_valid && out_ready.
- Simultaneous push and pop: count unchanged; both pointers advance. Valid when full and when count==1.
- Output style: first-word-fall-through.
  - out_valid = !empty.
  - out_* reflect the head entry in the same cycle the entry becomes resident, i.e. the cycle after its push.
  - A push into an empty FIFO is visible to the sink with one cycle of latency.
- Pointers: AW bits, wrap modulo DEPTH. count is held separately; full/empty are derived from it.
- Sink stall: out_* stay stable while out_valid=1 and out_ready=0.
- clear=1: pointers, count, seq, drop_count and last_pc_valid are zeroed; FSM = IDLE. Same-cycle push and pop are discarded; out_valid=0 next cycle.
- Reset mid-transfer: any buffered records are lost; out_valid drops immediately (async).

Test Plan:
- Reset, trace_en=1 for 3 cycles with pc=0,4,8, out_ready=0 -> count=3; then out_ready=1 -> out_pc 0,4,8 with out_seq 0,1,2, then empty=1.
- out_ready=0, trace_en=1 for 20 cycles (pc incrementing by 4) -> full=1, count=16, drop_count=4; drained out_seq = 0..15.
- FIFO full with out_ready=1 and continuous capture -> count stays 16, drop_count unchanged, one record in and one out per cycle.
- pc sequence 0,4,8,8,8 -> HALTED after the second 8, 4 records buffered, later cycles ignored; trace_en toggling has no effect; clear -> IDLE, count=0, halted=0.
- trace_en pulsed 1,0,1 with pc=0x10 both times -> no halt (compare disabled after IDLE), 2 records buffered.
- Reset asserted asynchronously mid-drain with count=5 -> out_valid=0, count=0 before the next clk edge.

Source files
------------

// File: rtl/cpu_trace_fifo.sv
// Trace capture buffer for the single-cycle LEGv8 core: samples PC/opcode/ALU/memory
// records while enabled, stops on a branch-to-self halt, and drains them FWFT over valid/ready.
module cpu_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int SEQ_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             trace_en,
    input  logic [63:0]      cpu_pc,
    input  logic [10:0]      cpu_opcode,
    input  logic [63:0]      cpu_alu,
    input  logic [63:0]      cpu_mem,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_pc,
    output logic [10:0]      out_opcode,
    output logic [63:0]      out_alu,
    output logic [63:0]      out_mem,
    output logic [SEQ_W-1:0] out_seq,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic [SEQ_W-1:0] drop_count,
    output logic             halted
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [AW:0]      CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]      CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ZERO = AW'(0);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [SEQ_W-1:0] SEQ_ZERO = SEQ_W'(0);
    localparam logic [SEQ_W-1:0] SEQ_ONE  = SEQ_W'(1);
    localparam logic [SEQ_W-1:0] SEQ_MAX  = {SEQ_W{1'b1}};

    state_t             state_r, state_s;
    logic [63:0]        pc_mem_r  [DEPTH];
    logic [10:0]        op_mem_r  [DEPTH];
    logic [63:0]        alu_mem_r [DEPTH];
    logic [63:0]        dat_mem_r [DEPTH];
    logic [SEQ_W-1:0]   seq_mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r, rd_ptr_r;
    logic [AW:0]        count_r;
    logic [SEQ_W-1:0]   seq_r, drop_r;
    logic [63:0]        last_pc_r;
    logic               last_pc_valid_r;
    logic               capture_s, halt_hit_s, push_s, pop_s, drop_s;

    assign full       = (count_r == CNT_FULL);
    assign empty      = (count_r == CNT_ZERO);
    assign count      = count_r;
    assign drop_count = drop_r;
    assign halted     = (state_r == ST_HALTED);
    assign out_valid  = !empty;

    // Head entry is shown directly (FWFT); zeroed while the buffer holds nothing.
    assign out_pc     = out_valid ? pc_mem_r[rd_ptr_r]  : 64'd0;
    assign out_opcode = out_valid ? op_mem_r[rd_ptr_r]  : 11'd0;
    assign out_alu    = out_valid ? alu_mem_r[rd_ptr_r] : 64'd0;
    assign out_mem    = out_valid ? dat_mem_r[rd_ptr_r] : 64'd0;
    assign out_seq    = out_valid ? seq_mem_r[rd_ptr_r] : SEQ_ZERO;

    assign capture_s  = trace_en && ((state_r == ST_IDLE) || (state_r == ST_RUN));
    assign halt_hit_s = capture_s && last_pc_valid_r && (cpu_pc == last_pc_r);
    assign pop_s      = out_valid && out_ready;
    assign push_s     = capture_s && (!full || pop_s);
    assign drop_s     = capture_s && full && !pop_s;

    // Next-state logic for the capture FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (trace_en) state_s = ST_RUN;
                else          state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (!trace_en)      state_s = ST_IDLE;
                else if (halt_hit_s) state_s = ST_HALTED;
                else                 state_s = ST_RUN;
            end
            ST_HALTED: state_s = ST_HALTED;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Control state: FSM, pointers, occupancy, sequence/drop counters and halt reference.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            wr_ptr_r        <= PTR_ZERO;
            rd_ptr_r        <= PTR_ZERO;
            count_r         <= CNT_ZERO;
            seq_r           <= SEQ_ZERO;
            drop_r          <= SEQ_ZERO;
            last_pc_r       <= 64'd0;
            last_pc_valid_r <= 1'b0;
        end else if (clear) begin
            state_r         <= ST_IDLE;
            wr_ptr_r        <= PTR_ZERO;
            rd_ptr_r        <= PTR_ZERO;
            count_r         <= CNT_ZERO;
            seq_r           <= SEQ_ZERO;
            drop_r          <= SEQ_ZERO;
            last_pc_valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            if (push_s && !pop_s)      count_r <= count_r + CNT_ONE;
            else if (pop_s && !push_s) count_r <= count_r - CNT_ONE;
            if (capture_s) begin
                seq_r           <= seq_r + SEQ_ONE;
                last_pc_r       <= cpu_pc;
                last_pc_valid_r <= 1'b1;
            end else if (state_s == ST_IDLE) begin
                // Leaving for IDLE disarms the compare so a re-enable cannot false-halt.
                last_pc_valid_r <= 1'b0;
            end
            if (drop_s && (drop_r != SEQ_MAX)) drop_r <= drop_r + SEQ_ONE;
        end
    end

    // Record storage; no reset needed since reads are masked while empty.
    always_ff @(posedge clk) begin
        if (push_s && !clear && !reset) begin
            pc_mem_r[wr_ptr_r]  <= cpu_pc;
            op_mem_r[wr_ptr_r]  <= cpu_opcode;
            alu_mem_r[wr_ptr_r] <= cpu_alu;
            dat_mem_r[wr_ptr_r] <= cpu_mem;
            seq_mem_r[wr_ptr_r] <= seq_r;
        end
    end

endmodule

// File: tb/tb_cpu_trace_fifo.sv
// Scoreboard bench for cpu_trace_fifo: directed capture patterns push expected records,
// a negedge monitor pops and compares every accepted head record.
module tb_cpu_trace_fifo;

    typedef struct packed {
        logic [63:0] pc;
        logic [10:0] op;
        logic [63:0] alu;
        logic [63:0] mem;
        logic [15:0] seq;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset, clear, trace_en, out_ready;
    logic [63:0] cpu_pc, cpu_alu, cpu_mem;
    logic [10:0] cpu_opcode;
    logic        out_valid, full, empty, halted;
    logic [63:0] out_pc, out_alu, out_mem;
    logic [10:0] out_opcode;
    logic [15:0] out_seq, drop_count;
    logic [4:0]  count;

    rec_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    cpu_trace_fifo #(.DEPTH(16), .AW(4), .SEQ_W(16)) dut (
        .clk(clk), .reset(reset), .clear(clear), .trace_en(trace_en),
        .cpu_pc(cpu_pc), .cpu_opcode(cpu_opcode), .cpu_alu(cpu_alu), .cpu_mem(cpu_mem),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_opcode(out_opcode), .out_alu(out_alu), .out_mem(out_mem),
        .out_seq(out_seq), .count(count), .full(full), .empty(empty),
        .drop_count(drop_count), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic rec_t mk(input logic [63:0] pc, input logic [15:0] seq);
        rec_t r;
        r.pc  = pc;
        r.op  = pc[10:0] ^ 11'h5A5;
        r.alu = pc + 64'h1000;
        r.mem = ~pc;
        r.seq = seq;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive one cycle of core observation outputs; optionally log the record expected to be stored.
    task automatic cyc(input logic en, input logic [63:0] pc, input logic exp_push, input int seq);
        rec_t r;
        r          = mk(pc, 16'(seq));
        trace_en   = en;
        cpu_pc     = r.pc;
        cpu_opcode = r.op;
        cpu_alu    = r.alu;
        cpu_mem    = r.mem;
        if (exp_push) q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        out_ready = 1'b0;
        trace_en  = 1'b0;
        clear     = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        q.delete();
    endtask

    task automatic drain(input string name);
        trace_en  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (empty) break;
            @(posedge clk);
            #1;
        end
        chk({name, "_empty"}, 64'(empty), 64'd1);
        chk({name, "_sb_left"}, 64'(q.size()), 64'd0);
        out_ready = 1'b0;
    endtask

    // Monitor: every accepted head record must match the oldest expected record.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_checks++;
            if (q.size() == 0) begin
                $display("FAIL sb_unexpected: got pc=%0h seq=%0h expected no record", out_pc, out_seq);
            end else begin
                rec_t e;
                e = q.pop_front();
                if (out_pc === e.pc && out_opcode === e.op && out_alu === e.alu &&
                    out_mem === e.mem && out_seq === e.seq)
                    n_pass++;
                else
                    $display("FAIL sb_record: got pc=%0h op=%0h alu=%0h mem=%0h seq=%0h expected pc=%0h op=%0h alu=%0h mem=%0h seq=%0h",
                             out_pc, out_opcode, out_alu, out_mem, out_seq,
                             e.pc, e.op, e.alu, e.mem, e.seq);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; trace_en = 1'b0; out_ready = 1'b0;
        cpu_pc = 64'd0; cpu_opcode = 11'd0; cpu_alu = 64'd0; cpu_mem = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        reset = 1'b0;

        // Three captures held back, then drained in order.
        cyc(1'b1, 64'h0, 1'b1, 0);
        chk("t1_fwft_valid", 64'(out_valid), 64'd1);
        cyc(1'b1, 64'h4, 1'b1, 1);
        cyc(1'b1, 64'h8, 1'b1, 2);
        cyc(1'b0, 64'hC, 1'b0, 0);
        chk("t1_count", 64'(count), 64'd3);
        drain("t1");

        // Overflow: 20 captures into 16 entries.
        do_clear();
        for (int i = 0; i < 20; i++) cyc(1'b1, 64'(i * 4), i < 16, i);
        cyc(1'b0, 64'h1000, 1'b0, 0);
        chk("t2_full", 64'(full), 64'd1);
        chk("t2_count", 64'(count), 64'd16);
        chk("t2_drop", 64'(drop_count), 64'd4);
        chk("t2_halted", 64'(halted), 64'd0);
        drain("t2");

        // Full with a ready sink: one in, one out each cycle.
        do_clear();
        for (int i = 0; i < 16; i++) cyc(1'b1, 64'h100 + 64'(i * 4), 1'b1, i);
        chk("t3_full", 64'(full), 64'd1);
        out_ready = 1'b1;
        for (int i = 16; i < 22; i++) begin
            cyc(1'b1, 64'h100 + 64'(i * 4), 1'b1, i);
            chk("t3_count", 64'(count), 64'd16);
        end
        chk("t3_drop", 64'(drop_count), 64'd0);
        drain("t3");

        // Branch-to-self halt.
        do_clear();
        cyc(1'b1, 64'h0, 1'b1, 0);
        cyc(1'b1, 64'h4, 1'b1, 1);
        cyc(1'b1, 64'h8, 1'b1, 2);
        chk("t4_not_halted", 64'(halted), 64'd0);
        cyc(1'b1, 64'h8, 1'b1, 3);
        chk("t4_halted", 64'(halted), 64'd1);
        cyc(1'b1, 64'h8, 1'b0, 0);
        cyc(1'b0, 64'hC, 1'b0, 0);
        cyc(1'b1, 64'h10, 1'b0, 0);
        chk("t4_count", 64'(count), 64'd4);
        chk("t4_still_halted", 64'(halted), 64'd1);
        do_clear();
        chk("t4_clr_count", 64'(count), 64'd0);
        chk("t4_clr_halted", 64'(halted), 64'd0);
        chk("t4_clr_valid", 64'(out_valid), 64'd0);

        // Same PC across an IDLE gap must not halt.
        cyc(1'b1, 64'h10, 1'b1, 0);
        cyc(1'b0, 64'h10, 1'b0, 0);
        cyc(1'b1, 64'h10, 1'b1, 1);
        cyc(1'b0, 64'h10, 1'b0, 0);
        chk("t5_halted", 64'(halted), 64'd0);
        chk("t5_count", 64'(count), 64'd2);
        drain("t5");

        // Asynchronous reset while the sink is draining.
        do_clear();
        for (int i = 0; i < 5; i++) cyc(1'b1, 64'h200 + 64'(i * 8), 1'b0, i);
        cyc(1'b0, 64'h0, 1'b0, 0);
        chk("t6_count", 64'(count), 64'd5);
        out_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_valid", 64'(out_valid), 64'd0);
        chk("t6_async_count", 64'(count), 64'd0);
        q.delete();
        reset = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_post_empty", 64'(empty), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
